instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage between the program counter and instruction memory. On request it
//  captures the current PC into an address register and performs a handshaked memory
//  read. It latches the returned word into the instruction register (IR) and pulses
//  inc_pc so the PC register advances by one. The IR output feeds the decode/control unit.
// PARAMETERS
//  ADDR_W   9    memory word-address width; mem_addr = pc_in[ADDR_W-1:0]
//  TIMEOUT  16   max cycles waiting for mem_ready (used only with IFU_TIMEOUT_EN); >=1
//  IR_INIT  0    IR value after reset
// PORTS
//  clk        in   1       clock, all state updates on rising edge
//  clr        in   1       synchronous reset, active-low (clr==0 resets on the clock edge)
//  fetch_req  in   1       start a fetch; sampled only in IDLE
//  flush      in   1       discard the in-flight fetch (branch/jump taken)
//  pc_in      in   32      current PC value (Q of the PC register)
//  mem_ready  in   1       memory has valid data on mem_data this cycle
//  mem_data   in   32      instruction word from memory
//  mem_addr   out  ADDR_W  registered word address to memory
//  mem_rd     out  1       read strobe, held high until mem_ready is sampled
//  ir_out     out  32      instruction register
//  ir_valid   out  1       ir_out holds a completed, undiscarded fetch
//  inc_pc     out  1       1-cycle pulse to the PC register increment input
//  busy       out  1       high in WAIT and DONE
//  fetch_err  out  1       sticky timeout flag (tied 0 without IFU_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (clr==0 at edge): state=IDLE, mem_addr=0, mem_rd=0, ir_out=IR_INIT, ir_valid=0,
//   inc_pc=0, fetch_err=0, discard=0, timer=0. Reset overrides every other input, mid-fetch too:
//   mem_rd drops at that edge and no inc_pc is produced.
//  States: IDLE -> WAIT -> DONE -> IDLE. All outputs are registered.
//  IDLE: if fetch_req: mem_addr<=pc_in[ADDR_W-1:0], mem_rd<=1, ir_valid<=0, fetch_err<=0,
//   discard<=flush, goto WAIT. Otherwise hold. flush alone in IDLE has no effect.
//  WAIT: mem_rd stays 1. flush==1 sets discard<=1. Same-cycle mem_ready is still discarded.
//   On mem_ready==1: mem_rd<=0.
//   If !(discard|flush): ir_out<=mem_data, ir_valid<=1, inc_pc<=1, goto DONE.
//   Otherwise: IR unchanged, no pulse, discard<=0, goto IDLE.
//  DONE: inc_pc<=0, goto IDLE. fetch_req is ignored here. ir_valid held until next accepted fetch.
//  Latency: fetch_req sampled at edge E0 gives mem_rd=1 after E0. mem_ready sampled at edge Ek
//   gives ir_valid=1 and inc_pc=1 after Ek, for exactly one cycle of inc_pc.
//   Zero-wait memory (ready with rd): 2 edges from request to IR.
//  pc_in is sampled only at request acceptance. Later PC changes do not affect the in-flight address.
//  Back-to-back: minimum 3 cycles per fetch (IDLE, WAIT, DONE).
// CONFIGURATION
//  IFU_TIMEOUT_EN defined:
//   - An up-counter timer clears on entry to WAIT and increments each WAIT cycle without mem_ready.
//   - If timer reaches TIMEOUT-1 with mem_ready still 0: mem_rd<=0, fetch_err<=1, goto IDLE.
//     No IR update and no inc_pc.
//   - mem_ready on that same edge wins and completes the fetch normally.
//   - fetch_err is sticky until the next accepted fetch_req or reset.
//  IFU_TIMEOUT_EN undefined: no timer logic; WAIT lasts until mem_ready; fetch_err constant 0.
// TESTING
//  1 Reset: clr=0 for 2 edges with fetch_req=1 -> all outputs at reset values, ir_out=IR_INIT, mem_rd=0.
//  2 Zero-wait: pc_in=0x25, fetch_req pulse, mem_ready=1, mem_data=0xA5A5_0001
//     -> mem_addr=0x25; 2 edges later ir_out=0xA5A50001, ir_valid=1; inc_pc high exactly 1 cycle.
//  3 Wait states: mem_ready asserted 4 cycles after mem_rd -> mem_rd high 4 cycles + ready cycle.
//     ir_valid rises the edge after ready. fetch_req held high in DONE is ignored.
//  4 Flush: flush=1 in the 2nd WAIT cycle, then mem_ready with 0xDEAD_BEEF
//     -> ir_out keeps old value, ir_valid=0, no inc_pc, back in IDLE.
//  5 Reset mid-fetch: clr=0 while in WAIT -> mem_rd=0 next edge; later mem_ready is ignored; no inc_pc.
//  6 IFU_TIMEOUT_EN, TIMEOUT=4, mem_ready never asserted -> after 4 WAIT cycles mem_rd=0, fetch_err=1.
//     Next fetch_req clears fetch_err. Without the macro: mem_rd stays high and fetch_err=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: captures the PC, performs a handshaked instruction-memory read and
// latches the word into the IR. Optional memory timeout enabled by `define IFU_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter int          ADDR_W  = 9,
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] IR_INIT = 32'h0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              fetch_req,
  input  logic              flush,
  input  logic [31:0]       pc_in,
  input  logic              mem_ready,
  input  logic [31:0]       mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic [31:0]       ir_out,
  output logic              ir_valid,
  output logic              inc_pc,
  output logic              busy,
  output logic              fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t state, state_nxt;
  logic   discard;
  logic   timeout;
  logic   kill;

  // A flush arriving together with mem_ready still discards the returned word
  assign kill = discard | flush;

  logic unused_bits;
  assign unused_bits = ^pc_in[31:ADDR_W] ^ (TIMEOUT > 0);

`ifdef IFU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer;

  assign timeout = (state == S_WAIT) && !mem_ready && (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!clr)
      timer <= '0;
    else if (state != S_WAIT)
      timer <= '0;
    else if (!mem_ready)
      timer <= timer + 1'b1;
  end
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!clr)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (fetch_req) state_nxt = S_WAIT;
      S_WAIT: begin
        if (mem_ready)
          state_nxt = kill ? S_IDLE : S_DONE;
        else if (timeout)
          state_nxt = S_IDLE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs; inc_pc defaults low so it can only ever be a single-cycle pulse
  always_ff @(posedge clk) begin
    if (!clr) begin
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      ir_out   <= IR_INIT;
      ir_valid <= 1'b0;
      inc_pc   <= 1'b0;
      busy     <= 1'b0;
      discard  <= 1'b0;
`ifdef IFU_TIMEOUT_EN
      fetch_err <= 1'b0;
`endif
    end else begin
      inc_pc <= 1'b0;
      busy   <= (state_nxt != S_IDLE);
      case (state)
        S_IDLE: begin
          if (fetch_req) begin
            mem_addr <= pc_in[ADDR_W-1:0];
            mem_rd   <= 1'b1;
            ir_valid <= 1'b0;
            discard  <= flush;
`ifdef IFU_TIMEOUT_EN
            fetch_err <= 1'b0;
`endif
          end
        end
        S_WAIT: begin
          if (flush) discard <= 1'b1;
          if (mem_ready) begin
            mem_rd <= 1'b0;
            if (!kill) begin
              ir_out   <= mem_data;
              ir_valid <= 1'b1;
              inc_pc   <= 1'b1;
            end else begin
              discard <= 1'b0;
            end
          end else if (timeout) begin
            mem_rd  <= 1'b0;
            discard <= 1'b0;
`ifdef IFU_TIMEOUT_EN
            fetch_err <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table for single fetches plus
// hand sequences for mid-fetch reset and the memory-timeout corner.
module tb_instr_fetch_unit;

  localparam logic [31:0] IRI = 32'h0000_0013;
`ifdef IFU_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr, fetch_req, flush, mem_ready;
  logic [31:0] pc_in, mem_data;
  logic [8:0]  mem_addr;
  logic        mem_rd, ir_valid, inc_pc, busy, fetch_err;
  logic [31:0] ir_out;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.ADDR_W(9), .TIMEOUT(4), .IR_INIT(IRI)) dut (
    .clk(clk), .clr(clr), .fetch_req(fetch_req), .flush(flush), .pc_in(pc_in),
    .mem_ready(mem_ready), .mem_data(mem_data), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .ir_out(ir_out), .ir_valid(ir_valid), .inc_pc(inc_pc), .busy(busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr, req, flush;
    logic [31:0] pc;
    logic        rdy;
    logic [31:0] data;
    logic [8:0]  addr;
    logic        rd;
    logic [31:0] ir;
    logic        valid, inc, bsy, err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic c, logic r, logic f, logic [31:0] p, logic y, logic [31:0] d,
                              logic [8:0] a, logic rd, logic [31:0] ir, logic v, logic i, logic b);
    vec_t t;
    t.clr = c; t.req = r; t.flush = f; t.pc = p; t.rdy = y; t.data = d;
    t.addr = a; t.rd = rd; t.ir = ir; t.valid = v; t.inc = i; t.bsy = b; t.err = 1'b0;
    return t;
  endfunction

  // Drive inputs, then advance one rising edge and settle on the falling edge
  task automatic applyStimulus(logic c, logic r, logic f, logic [31:0] p, logic y, logic [31:0] d);
    clr = c; fetch_req = r; flush = f; pc_in = p; mem_ready = y; mem_data = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(string tag, logic [8:0] a, logic rd, logic [31:0] ir,
                          logic v, logic i, logic b, logic e);
    checkOutput({tag, ".mem_addr"},  32'(mem_addr),  32'(a));
    checkOutput({tag, ".mem_rd"},    32'(mem_rd),    32'(rd));
    checkOutput({tag, ".ir_out"},    ir_out,         ir);
    checkOutput({tag, ".ir_valid"},  32'(ir_valid),  32'(v));
    checkOutput({tag, ".inc_pc"},    32'(inc_pc),    32'(i));
    checkOutput({tag, ".busy"},      32'(busy),      32'(b));
    checkOutput({tag, ".fetch_err"}, 32'(fetch_err), 32'(e));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clr = 1'b0; fetch_req = 1'b0; flush = 1'b0; pc_in = '0; mem_ready = 1'b0; mem_data = '0;
    @(negedge clk);

    // reset with fetch_req held high
    vecs.push_back(mk(0,1,0,32'h25,0,32'h0,        9'h000,0,IRI,0,0,0));
    vecs.push_back(mk(0,1,0,32'h25,0,32'h0,        9'h000,0,IRI,0,0,0));
    // zero-wait fetch
    vecs.push_back(mk(1,1,0,32'h25,1,32'hA5A50001, 9'h025,1,IRI,0,0,1));
    vecs.push_back(mk(1,0,0,32'h25,1,32'hA5A50001, 9'h025,0,32'hA5A50001,1,1,1));
    vecs.push_back(mk(1,0,0,32'h25,0,32'h0,        9'h025,0,32'hA5A50001,1,0,0));
    vecs.push_back(mk(1,0,0,32'h25,0,32'h0,        9'h025,0,32'hA5A50001,1,0,0));
    // four wait states, PC truncated to 9 bits and changed mid-fetch, req held in DONE
    vecs.push_back(mk(1,1,0,32'h342,0,32'h0,       9'h142,1,32'hA5A50001,0,0,1));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1,1,0,32'h77,0,32'h0,      9'h142,1,32'hA5A50001,0,0,1));
    vecs.push_back(mk(1,1,0,32'h77,1,32'h0BADF00D, 9'h142,0,32'h0BADF00D,1,1,1));
    vecs.push_back(mk(1,1,0,32'h77,0,32'h0,        9'h142,0,32'h0BADF00D,1,0,0));
    // flush in second WAIT cycle
    vecs.push_back(mk(1,1,0,32'h10,0,32'h0,        9'h010,1,32'h0BADF00D,0,0,1));
    vecs.push_back(mk(1,0,0,32'h10,0,32'h0,        9'h010,1,32'h0BADF00D,0,0,1));
    vecs.push_back(mk(1,0,1,32'h10,0,32'h0,        9'h010,1,32'h0BADF00D,0,0,1));
    vecs.push_back(mk(1,0,0,32'h10,1,32'hDEADBEEF, 9'h010,0,32'h0BADF00D,0,0,0));
    // flush on the same edge as mem_ready, then flush alone in IDLE
    vecs.push_back(mk(1,1,0,32'h11,0,32'h0,        9'h011,1,32'h0BADF00D,0,0,1));
    vecs.push_back(mk(1,0,1,32'h11,1,32'hCAFEF00D, 9'h011,0,32'h0BADF00D,0,0,0));
    vecs.push_back(mk(1,0,1,32'h11,0,32'h0,        9'h011,0,32'h0BADF00D,0,0,0));
    // flush together with the accepted request
    vecs.push_back(mk(1,1,1,32'h12,0,32'h0,        9'h012,1,32'h0BADF00D,0,0,1));
    vecs.push_back(mk(1,0,0,32'h12,1,32'h11111111, 9'h012,0,32'h0BADF00D,0,0,0));
    // clean fetch after the discards
    vecs.push_back(mk(1,1,0,32'h13,0,32'h0,        9'h013,1,32'h0BADF00D,0,0,1));
    vecs.push_back(mk(1,0,0,32'h13,1,32'h22223333, 9'h013,0,32'h22223333,1,1,1));
    vecs.push_back(mk(1,0,0,32'h13,0,32'h0,        9'h013,0,32'h22223333,1,0,0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].clr, vecs[i].req, vecs[i].flush, vecs[i].pc, vecs[i].rdy, vecs[i].data);
      checkAll($sformatf("v%0d", i), vecs[i].addr, vecs[i].rd, vecs[i].ir,
               vecs[i].valid, vecs[i].inc, vecs[i].bsy, vecs[i].err);
    end

    // reset while waiting on memory; a later mem_ready must be ignored
    applyStimulus(1, 1, 0, 32'h30, 0, 32'h0);
    checkAll("rst.acc", 9'h030, 1, 32'h22223333, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 32'h30, 0, 32'h0);
    checkAll("rst.wait", 9'h030, 1, 32'h22223333, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 32'h30, 0, 32'h0);
    checkAll("rst.hit", 9'h000, 0, IRI, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 0, 32'h30, 1, 32'h55555555);
      checkAll($sformatf("rst.after%0d", k), 9'h000, 0, IRI, 0, 0, 0, 0);
    end

    // memory never answers: timeout after 4 WAIT cycles only when enabled
    applyStimulus(1, 1, 0, 32'h40, 0, 32'h0);
    checkAll("to.acc", 9'h040, 1, IRI, 0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, 0, 0, 32'h40, 0, 32'h0);
      checkAll($sformatf("to.w%0d", k), 9'h040, !(TO_EN && k == 4), IRI, 0, 0,
               !(TO_EN && k == 4), TO_EN && k == 4);
    end
    applyStimulus(1, 1, 0, 32'h41, 0, 32'h0);
    checkAll("to.req", TO_EN ? 9'h041 : 9'h040, 1, IRI, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 32'h41, 1, 32'h77777777);
    checkAll("to.done", TO_EN ? 9'h041 : 9'h040, 0, 32'h77777777, 1, 1, 1, 0);
    applyStimulus(1, 0, 0, 32'h41, 0, 32'h0);
    checkAll("to.idle", TO_EN ? 9'h041 : 9'h040, 0, 32'h77777777, 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
